// File: rtl/lcd_frame_capture_pkg.sv
// Shared definitions for the LCD frame capture model: capture states and
// default panel geometry.
package lcd_frame_capture_pkg;

   typedef enum logic [1:0] {
      WAIT_VS,
      ACTIVE,
      DONE
   } state_t;

   localparam int unsigned LCD_H_ACTIVE       = 160;
   localparam int unsigned LCD_V_ACTIVE       = 144;
   localparam int unsigned LCD_BYTES_PER_LINE = LCD_H_ACTIVE / 4;

endpackage

// File: rtl/lcd_frame_capture_sync_edge_det.sv
// Registers a 1-bit sync input and flags its rising edge in the same cycle
// the input first goes high.
module sync_edge_det (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_d,
   output logic o_rise
);

   logic r_q;

   // remember last cycle's level
   always_ff @(posedge i_clk) begin
      if (!i_rstn) r_q <= 1'b0;
      else         r_q <= i_d;
   end

   assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/lcd_frame_capture.sv
// LCD stream consumer: packs 2bpp pixels four per byte into a linear
// framebuffer, pulses frame_done per complete frame and flags geometry errors.
module lcd_frame_capture
   import lcd_frame_capture_pkg::*;
#(
   parameter int unsigned H_ACTIVE = LCD_H_ACTIVE,
   parameter int unsigned V_ACTIVE = LCD_V_ACTIVE,
   parameter int unsigned AW       = 13
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          hsync,
   input  logic          vsync,
   input  logic          pvalid,
   input  logic [1:0]    pixel,
   input  logic          clr_err,
   output logic          fb_we,
   output logic [AW-1:0] fb_addr,
   output logic [7:0]    fb_wdata,
   output logic          frame_done,
   output logic [15:0]   frame_count,
   output logic          err
);

   localparam int unsigned XW = $clog2(H_ACTIVE + 1);
   localparam int unsigned YW = $clog2(V_ACTIVE + 1);
   localparam logic [XW-1:0] L_H   = XW'(H_ACTIVE);
   localparam logic [YW-1:0] L_V   = YW'(V_ACTIVE);
   localparam logic [AW-1:0] L_BPL = AW'(H_ACTIVE / 4);

   state_t        r_state, w_state;
   logic [XW-1:0] r_x, w_x;
   logic [YW-1:0] r_y, w_y;
   logic [AW-1:0] r_line_base, w_line_base;
   logic [5:0]    r_pack, w_pack;
   logic          r_fb_we, w_fb_we;
   logic [AW-1:0] r_fb_addr, w_fb_addr;
   logic [7:0]    r_fb_wdata, w_fb_wdata;
   logic          r_frame_done, w_frame_done;
   logic [15:0]   r_frame_count, w_frame_count;
   logic          r_err, w_err_set;

   logic          w_hs_rise, w_vs_rise, w_accept;
   logic [YW-1:0] w_y_inc;

   sync_edge_det u_hs_edge (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_d    (hsync),
      .o_rise (w_hs_rise)
   );

   sync_edge_det u_vs_edge (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_d    (vsync),
      .o_rise (w_vs_rise)
   );

   assign w_accept = pvalid & ~hsync & ~vsync;
   assign w_y_inc  = r_y + 1'b1;

   // next-state, pixel packing, line/frame accounting and error detection
   always_comb begin
      w_state       = r_state;
      w_x           = r_x;
      w_y           = r_y;
      w_line_base   = r_line_base;
      w_pack        = r_pack;
      w_fb_we       = 1'b0;
      w_fb_addr     = r_fb_addr;
      w_fb_wdata    = r_fb_wdata;
      w_frame_done  = 1'b0;
      w_frame_count = r_frame_count;
      w_err_set     = 1'b0;

      case (r_state)
         WAIT_VS, DONE: begin
            if (w_vs_rise) begin
               w_state     = ACTIVE;
               w_x         = '0;
               w_y         = '0;
               w_line_base = '0;
               w_pack      = '0;
            end
         end
         ACTIVE: begin
            if (w_vs_rise) begin
               // frame restarted before all lines arrived
               w_err_set   = 1'b1;
               w_x         = '0;
               w_y         = '0;
               w_line_base = '0;
               w_pack      = '0;
            end else if (w_hs_rise) begin
               if (r_x != '0) begin
                  w_y         = w_y_inc;
                  w_line_base = r_line_base + L_BPL;
                  if (r_x != L_H) w_err_set = 1'b1;
                  if (w_y_inc == L_V) begin
                     w_frame_done  = 1'b1;
                     w_frame_count = r_frame_count + 16'd1;
                     w_state       = DONE;
                  end
               end
               w_x    = '0;
               w_pack = '0;
            end else if (w_accept) begin
               if (r_x < L_H) begin
                  w_pack = {r_pack[3:0], pixel};
                  w_x    = r_x + 1'b1;
                  if (r_x[1:0] == 2'b11) begin
                     w_fb_we    = 1'b1;
                     w_fb_addr  = r_line_base + AW'(r_x >> 2);
                     w_fb_wdata = {r_pack, pixel};
                  end
               end else begin
                  w_err_set = 1'b1;
               end
            end
         end
         default: w_state = WAIT_VS;
      endcase
   end

   // state and output registers; reset wins over everything
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= WAIT_VS;
         r_x           <= '0;
         r_y           <= '0;
         r_line_base   <= '0;
         r_pack        <= '0;
         r_fb_we       <= 1'b0;
         r_fb_addr     <= '0;
         r_fb_wdata    <= '0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_x           <= w_x;
         r_y           <= w_y;
         r_line_base   <= w_line_base;
         r_pack        <= w_pack;
         r_fb_we       <= w_fb_we;
         r_fb_addr     <= w_fb_addr;
         r_fb_wdata    <= w_fb_wdata;
         r_frame_done  <= w_frame_done;
         r_frame_count <= w_frame_count;
         r_err         <= clr_err ? 1'b0 : (r_err | w_err_set);
      end
   end

   assign fb_we       = r_fb_we;
   assign fb_addr     = r_fb_addr;
   assign fb_wdata    = r_fb_wdata;
   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign err         = r_err;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture with a write scoreboard.
module tb_lcd_frame_capture;

   localparam int unsigned H   = 160;
   localparam int unsigned V   = 144;
   localparam int unsigned AW  = 13;
   localparam int unsigned BPL = H / 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          hsync = 1'b0;
   logic          vsync = 1'b0;
   logic          pvalid = 1'b0;
   logic [1:0]    pixel = 2'd0;
   logic          clr_err = 1'b0;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [7:0]    fb_wdata;
   logic          frame_done;
   logic [15:0]   frame_count;
   logic          err;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t exp_q[$];
   wr_t obs_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  n_done   = 0;
   int  m_line   = 0;

   always #5 clk = ~clk;

   lcd_frame_capture #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .AW       (AW)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .hsync       (hsync),
      .vsync       (vsync),
      .pvalid      (pvalid),
      .pixel       (pixel),
      .clr_err     (clr_err),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_wdata    (fb_wdata),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .err         (err)
   );

   // capture DUT writes and frame pulses away from the active edge
   always @(negedge clk) begin
      if (fb_we === 1'b1) obs_q.push_back({fb_addr, fb_wdata});
      if (frame_done === 1'b1) n_done++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_vsync(input bit with_pix);
      vsync  = 1'b1;
      pvalid = with_pix;
      pixel  = 2'd3;
      tick();
      vsync  = 1'b0;
      pvalid = 1'b0;
      tick();
      m_line = 0;
   endtask

   // one line of npix pixels followed by an hsync pulse; expect=0 means the
   // DUT should ignore the whole line
   task automatic drive_line(input int npix, input bit rnd, input bit expect_w);
      logic [7:0] b;
      logic [1:0] p;
      b = 8'h00;
      for (int x = 0; x < npix; x++) begin
         p      = rnd ? 2'($urandom) : 2'(x % 4);
         pixel  = p;
         pvalid = 1'b1;
         if (expect_w && x < H) begin
            b = {b[5:0], p};
            if (x % 4 == 3)
               exp_q.push_back({AW'(m_line * BPL + x / 4), b});
         end
         tick();
      end
      pvalid = 1'b0;
      hsync  = 1'b1;
      tick();
      hsync  = 1'b0;
      tick();
      if (expect_w && npix > 0) m_line++;
   endtask

   task automatic full_frame(input bit rnd);
      for (int l = 0; l < V; l++) drive_line(H, rnd, 1'b1);
   endtask

   task automatic check_writes(input string tag);
      wr_t e;
      wr_t o;
      repeat (3) tick();
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({tag, "_addr"}, 32'(o.addr), 32'(e.addr));
         chk({tag, "_data"}, 32'(o.data), 32'(e.data));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic clear_err();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_we"},    32'(fb_we),       0);
      chk({tag, "_addr"},  32'(fb_addr),     0);
      chk({tag, "_wdata"}, 32'(fb_wdata),    0);
      chk({tag, "_done"},  32'(frame_done),  0);
      chk({tag, "_count"}, 32'(frame_count), 0);
      chk({tag, "_err"},   32'(err),         0);
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      chk_outputs_zero("reset");
      rstn = 1'b1;
      tick();

      // pixels before any vsync are ignored
      for (int i = 0; i < 50; i++) begin
         pvalid = 1'b1;
         pixel  = 2'(i % 4);
         tick();
         pvalid = 1'b0;
         tick();
      end
      check_writes("pre_vs");

      // nominal frame; the pixel coincident with vsync must be dropped
      pulse_vsync(1'b1);
      full_frame(1'b0);
      check_writes("frame1");
      chk("frame1_done", n_done, 1);
      chk("frame1_count", 32'(frame_count), 1);
      chk("frame1_err", 32'(err), 0);

      // DONE state ignores pixels and hsync
      drive_line(H, 1'b0, 1'b0);
      check_writes("done_ignore");
      chk("done_ignore_count", 32'(frame_count), 1);
      chk("done_ignore_pulses", n_done, 1);

      // long line 0: 164 pixels, surplus dropped
      pulse_vsync(1'b0);
      drive_line(H + 4, 1'b1, 1'b1);
      check_writes("long_line");
      chk("long_line_err", 32'(err), 1);
      clear_err();
      chk("long_line_clr", 32'(err), 0);

      // lines 1..2 normal, line 3 short (102 pixels)
      drive_line(H, 1'b1, 1'b1);
      drive_line(H, 1'b1, 1'b1);
      drive_line(102, 1'b1, 1'b1);
      check_writes("short_line");
      chk("short_line_err", 32'(err), 1);
      clear_err();
      chk("short_line_clr", 32'(err), 0);

      // lines 4..9: line 4 must start at byte 160
      chk("line4_model_base", m_line * BPL, 160);
      for (int l = 4; l < 10; l++) drive_line(H, 1'b1, 1'b1);
      check_writes("after_short");

      // short frame: vsync after 10 lines
      pulse_vsync(1'b0);
      chk("short_frame_err", 32'(err), 1);
      chk("short_frame_no_done", n_done, 1);
      clear_err();
      full_frame(1'b1);
      check_writes("frame3");
      chk("frame3_done", n_done, 2);
      chk("frame3_count", 32'(frame_count), 2);
      chk("frame3_err", 32'(err), 0);

      // reset mid-line after 2 pixels
      pulse_vsync(1'b0);
      for (int i = 0; i < 2; i++) begin
         pvalid = 1'b1;
         pixel  = 2'(i);
         tick();
      end
      pvalid = 1'b0;
      rstn   = 1'b0;
      tick();
      chk_outputs_zero("mid_reset");
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pvalid = 1'b1;
         pixel  = 2'(i % 4);
         tick();
      end
      pvalid = 1'b0;
      check_writes("mid_reset_wait");
      pulse_vsync(1'b1);
      full_frame(1'b0);
      check_writes("frame4");
      chk("frame4_done", n_done, 3);
      chk("frame4_count", 32'(frame_count), 1);
      chk("frame4_err", 32'(err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
